// File: rtl/conv_row_sched_if.sv
// conv_row_sched_if
//
// Bundles every non-clock/reset signal of the row scheduler.
//   slave  : the scheduler itself. Takes job control, PE psum and the
//            downstream ready. Drives status, buffer reads, PE strobes and
//            the output register.
//   master : the surrounding datapath/controller (line buffers, PE,
//            write-back). Sees the opposite directions.
interface conv_row_sched_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    // job control / status
    logic                    start;
    logic                    abort;
    logic [3:0]              cfg_kernel_size;
    logic [ADDR_WIDTH-1:0]   cfg_row_len;
    logic                    busy;
    logic                    done;
    logic                    cfg_err;
    // line-buffer reads (data valid the cycle after rd_en)
    logic                    ifmap_rd_en;
    logic [ADDR_WIDTH-1:0]   ifmap_rd_addr;
    logic                    fltr_rd_en;
    logic [3:0]              fltr_rd_addr;
    // PE strobes
    logic                    pe_en;
    logic                    pe_first;
    logic                    pe_last;
    // psum from PE and the registered output
    logic [2*DATA_WIDTH-1:0] psum_in;
    logic                    psum_in_valid;
    logic [2*DATA_WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;

    modport slave (
        input  start, abort, cfg_kernel_size, cfg_row_len,
        input  psum_in, psum_in_valid, out_ready,
        output busy, done, cfg_err,
        output ifmap_rd_en, ifmap_rd_addr, fltr_rd_en, fltr_rd_addr,
        output pe_en, pe_first, pe_last,
        output out_data, out_valid, out_last
    );

    modport master (
        output start, abort, cfg_kernel_size, cfg_row_len,
        output psum_in, psum_in_valid, out_ready,
        input  busy, done, cfg_err,
        input  ifmap_rd_en, ifmap_rd_addr, fltr_rd_en, fltr_rd_addr,
        input  pe_en, pe_first, pe_last,
        input  out_data, out_valid, out_last
    );
endinterface

// File: rtl/conv_row_sched.sv
// conv_row_sched
//
// Sequencing controller for one PE of the convolution array. Walks a 1-D
// ifmap row of length W with a K-tap filter at stride 1, issuing one tap
// (ifmap + filter read) per cycle, driving the PE enable/first/last strobes
// one cycle later, and capturing each finished psum into a single-entry
// ready/valid output register. A held output (out_valid & ~out_ready)
// stalls issue and freezes the PE.
//
// Ports:
//   clk   - clock, rising edge
//   rstn  - asynchronous active-low reset
//   bus   - conv_row_sched_if.slave: start/abort/cfg in, busy/done/cfg_err
//           out, ifmap/filter read ports, PE strobes, psum in, output
//           handshake (out_data/out_valid/out_ready/out_last)
module conv_row_sched #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic            clk,
    input  logic            rstn,
    conv_row_sched_if.slave bus
);
    localparam logic [3:0]            KMAX   = 4'(KERNEL_SIZE);
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                  state_q,      state_d;
    logic [3:0]              k_q,          k_d;
    logic [ADDR_WIDTH-1:0]   nout_q,       nout_d;
    logic [3:0]              t_q,          t_d;
    logic [ADDR_WIDTH-1:0]   o_q,          o_d;
    logic [ADDR_WIDTH-1:0]   cap_cnt_q,    cap_cnt_d;
    logic                    cfg_err_q,    cfg_err_d;
    // Issue pipeline: a tap issued in cycle n is presented to the PE in the
    // first non-stalled cycle after n, when the buffer data is valid.
    logic                    pend_q,       pend_d;
    logic                    pend_first_q, pend_first_d;
    logic                    pend_last_q,  pend_last_d;
    logic [2*DATA_WIDTH-1:0] out_data_q,   out_data_d;
    logic                    out_valid_q,  out_valid_d;
    logic                    out_last_q,   out_last_d;

    logic stall;
    logic issue;
    logic tap_last;
    logic out_final;
    logic accept;
    logic start_ok;
    logic cfg_bad;

    assign stall     = out_valid_q & ~bus.out_ready;
    assign issue     = (state_q == S_RUN) & ~stall;
    assign tap_last  = (t_q == k_q - 4'd1);
    assign out_final = (o_q == nout_q - A_ONE);
    assign accept    = out_valid_q & bus.out_ready;
    assign start_ok  = bus.start & ~bus.abort & (state_q == S_IDLE);
    assign cfg_bad   = (bus.cfg_kernel_size == 4'd0)
                     | (bus.cfg_kernel_size > KMAX)
                     | (bus.cfg_row_len < ADDR_WIDTH'(bus.cfg_kernel_size));

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        nout_d       = nout_q;
        t_d          = t_q;
        o_d          = o_q;
        cap_cnt_d    = cap_cnt_q;
        cfg_err_d    = 1'b0;
        pend_d       = pend_q;
        pend_first_d = pend_first_q;
        pend_last_d  = pend_last_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d   = S_RUN;
                        k_d       = bus.cfg_kernel_size;
                        nout_d    = bus.cfg_row_len
                                  - ADDR_WIDTH'(bus.cfg_kernel_size) + A_ONE;
                        t_d       = 4'd0;
                        o_d       = '0;
                        cap_cnt_d = '0;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (tap_last) begin
                        t_d = 4'd0;
                        o_d = o_q + A_ONE;
                        if (out_final) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        t_d = t_q + 4'd1;
                    end
                end
            end
            S_DRAIN: begin
                // Last capture always lands after the last issue, so the
                // final beat is only ever accepted here.
                if (accept && out_last_q) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pipeline advances only when the output is not held; otherwise the
        // pending tap waits with the buffers holding its data.
        if (!stall) begin
            pend_d       = issue;
            pend_first_d = issue & (t_q == 4'd0);
            pend_last_d  = issue & tap_last;
        end

        // Output register: a capture wins over a same-cycle acceptance, so
        // the new psum replaces the accepted one and valid stays high.
        if (bus.psum_in_valid) begin
            out_data_d  = bus.psum_in;
            out_valid_d = 1'b1;
            out_last_d  = (cap_cnt_q == nout_q - A_ONE);
            cap_cnt_d   = cap_cnt_q + A_ONE;
        end else if (accept) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (bus.abort) begin
            state_d      = S_IDLE;
            t_d          = 4'd0;
            o_d          = '0;
            cap_cnt_d    = '0;
            cfg_err_d    = 1'b0;
            pend_d       = 1'b0;
            pend_first_d = 1'b0;
            pend_last_d  = 1'b0;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            k_q          <= 4'd0;
            nout_q       <= '0;
            t_q          <= 4'd0;
            o_q          <= '0;
            cap_cnt_q    <= '0;
            cfg_err_q    <= 1'b0;
            pend_q       <= 1'b0;
            pend_first_q <= 1'b0;
            pend_last_q  <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            nout_q       <= nout_d;
            t_q          <= t_d;
            o_q          <= o_d;
            cap_cnt_q    <= cap_cnt_d;
            cfg_err_q    <= cfg_err_d;
            pend_q       <= pend_d;
            pend_first_q <= pend_first_d;
            pend_last_q  <= pend_last_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    assign bus.busy          = (state_q == S_RUN) | (state_q == S_DRAIN);
    assign bus.done          = (state_q == S_FLUSH);
    assign bus.cfg_err       = cfg_err_q;
    assign bus.ifmap_rd_en   = issue;
    assign bus.ifmap_rd_addr = o_q + ADDR_WIDTH'(t_q);
    assign bus.fltr_rd_en    = issue;
    assign bus.fltr_rd_addr  = t_q;
    // PE strobes are gated by stall so the PE freezes with the pipeline.
    assign bus.pe_en         = pend_q & ~stall;
    assign bus.pe_first      = pend_first_q & ~stall;
    assign bus.pe_last       = pend_last_q & ~stall;
    assign bus.out_data      = out_data_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_last      = out_last_q;
endmodule

// File: tb/tb_conv_row_sched.sv
module tb_conv_row_sched;
    localparam int DW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    conv_row_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    conv_row_sched #(.DATA_WIDTH(DW), .KERNEL_SIZE(3), .ADDR_WIDTH(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- line buffers and PE stimulus models ----------------
    logic [DW-1:0]   ifmap_mem [0:1023];
    logic [DW-1:0]   fltr_mem  [0:15];
    logic [DW-1:0]   ifmap_data = '0;
    logic [DW-1:0]   fltr_data  = '0;
    logic [2*DW-1:0] acc_q      = '0;
    logic [2*DW-1:0] prod;

    always @(posedge clk) begin
        if (bus.ifmap_rd_en) ifmap_data <= ifmap_mem[bus.ifmap_rd_addr];
        if (bus.fltr_rd_en)  fltr_data  <= fltr_mem[bus.fltr_rd_addr];
        if (bus.pe_en)       acc_q      <= bus.psum_in;
    end

    assign prod              = 32'(ifmap_data) * 32'(fltr_data);
    assign bus.psum_in       = bus.pe_first ? prod : acc_q + prod;
    assign bus.psum_in_valid = bus.pe_en & bus.pe_last;

    // ---------------- reference expectations and monitor ----------------
    int          exp_addr_q [$];
    logic [31:0] exp_psum_q [$];
    bit          mon_on = 1'b0;
    int          job_k, job_n;
    int          iss_idx, pe_idx, beat_idx, done_cnt;
    int          first_iss_cyc, last_iss_cyc, hs_last_cyc;
    int          cyc = 0;
    int          done_any = 0;
    bit          prev_pv = 1'b0;
    logic [31:0] prev_psum;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.done) done_any++;
        if (mon_on) begin
            if (bus.ifmap_rd_en) begin
                if (iss_idx < exp_addr_q.size()) begin
                    check("ifmap_addr", bus.ifmap_rd_addr, exp_addr_q[iss_idx]);
                    check("fltr_addr", bus.fltr_rd_addr, iss_idx % job_k);
                end else begin
                    check("extra_issue", 1, 0);
                end
                check("fltr_en", bus.fltr_rd_en, 1);
                if (iss_idx == 0) first_iss_cyc = cyc;
                last_iss_cyc = cyc;
                iss_idx++;
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("stall_pe_en", bus.pe_en, 0);
                check("stall_rd_en", bus.ifmap_rd_en, 0);
            end
            if (bus.pe_en) begin
                check("pe_first", bus.pe_first, (pe_idx % job_k) == 0);
                check("pe_last", bus.pe_last, (pe_idx % job_k) == job_k - 1);
                pe_idx++;
            end
            if (prev_pv) begin
                check("cap_valid", bus.out_valid, 1);
                check("cap_data", bus.out_data, prev_psum);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (beat_idx < job_n) begin
                    check("out_data", bus.out_data, exp_psum_q[beat_idx]);
                    check("out_last", bus.out_last, beat_idx == job_n - 1);
                end else begin
                    check("extra_beat", 1, 0);
                end
                if (bus.out_last) hs_last_cyc = cyc;
                beat_idx++;
            end
            if (bus.done) begin
                check("done_timing", cyc, hs_last_cyc + 1);
                check("done_beats", beat_idx, job_n);
                done_cnt++;
            end
            prev_pv   = bus.psum_in_valid;
            prev_psum = bus.psum_in;
        end else begin
            prev_pv = 1'b0;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},     bus.busy, 0);
        check({tag, "_done"},     bus.done, 0);
        check({tag, "_cfg_err"},  bus.cfg_err, 0);
        check({tag, "_ird_en"},   bus.ifmap_rd_en, 0);
        check({tag, "_frd_en"},   bus.fltr_rd_en, 0);
        check({tag, "_iaddr"},    bus.ifmap_rd_addr, 0);
        check({tag, "_faddr"},    bus.fltr_rd_addr, 0);
        check({tag, "_pe_en"},    bus.pe_en, 0);
        check({tag, "_pe_first"}, bus.pe_first, 0);
        check({tag, "_pe_last"},  bus.pe_last, 0);
        check({tag, "_ovalid"},   bus.out_valid, 0);
        check({tag, "_olast"},    bus.out_last, 0);
        check({tag, "_odata"},    bus.out_data, 0);
    endtask

    // mode: 0 = out_ready always 1, 1 = toggle every 3 cycles, 2 = random
    task automatic run_job(input int k, input int w, input int mode, input int abort_at);
        int n;
        int cij;
        int done_before;
        bit finished;
        logic [31:0] s;
        n = w - k + 1;
        exp_addr_q.delete();
        exp_psum_q.delete();
        for (int i = 0; i < w; i++) ifmap_mem[i] = DW'($urandom);
        for (int t = 0; t < k; t++) fltr_mem[t] = DW'($urandom);
        for (int o = 0; o < n; o++) begin
            s = 32'd0;
            for (int t = 0; t < k; t++) begin
                exp_addr_q.push_back(o + t);
                s = s + 32'(ifmap_mem[o + t]) * 32'(fltr_mem[t]);
            end
            exp_psum_q.push_back(s);
        end

        @(posedge clk); #1;
        bus.start           = 1'b1;
        bus.cfg_kernel_size = 4'(k);
        bus.cfg_row_len     = AW'(w);
        bus.out_ready       = 1'b1;
        job_k = k; job_n = n;
        iss_idx = 0; pe_idx = 0; beat_idx = 0; done_cnt = 0;
        hs_last_cyc = -10; first_iss_cyc = 0; last_iss_cyc = 0;
        mon_on = 1'b1;
        @(posedge clk); #1;
        bus.start           = 1'b0;
        bus.cfg_kernel_size = 4'($urandom);
        bus.cfg_row_len     = AW'($urandom);
        check("busy_rise", bus.busy, 1);
        check("first_issue", bus.ifmap_rd_en, 1);
        check("first_pe_en_low", bus.pe_en, 0);
        cij = 1;
        finished = 1'b0;
        for (int i = 0; i < 4000 && !finished; i++) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ((cij / 3) % 2) == 0;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
            bus.start = (abort_at == 0) && (i == 2);
            bus.abort = (abort_at != 0) && (cij == abort_at);
            @(posedge clk); #1;
            cij++;
            if (i == 0) begin
                check("pe_en_c2", bus.pe_en, 1);
                check("pe_first_c2", bus.pe_first, 1);
            end
            if (bus.abort) begin
                bus.abort = 1'b0;
                mon_on = 1'b0;
                done_before = done_any;
                check("abort_busy", bus.busy, 0);
                check("abort_ovalid", bus.out_valid, 0);
                check("abort_pe_en", bus.pe_en, 0);
                check("abort_rd_en", bus.ifmap_rd_en, 0);
                repeat (6) @(posedge clk);
                #1;
                check("abort_no_done", done_any, done_before);
                check("abort_idle", bus.busy, 0);
                finished = 1'b1;
            end else if (done_cnt != 0) begin
                finished = 1'b1;
                check("done_once", done_cnt, 1);
                check("post_done", bus.done, 0);
                check("post_busy", bus.busy, 0);
                check("beats", beat_idx, n);
                check("issues", iss_idx, n * k);
                check("pe_taps", pe_idx, n * k);
                if (mode == 0) check("issue_span", last_iss_cyc - first_iss_cyc + 1, n * k);
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (!finished) check("job_timeout", 0, 1);
        mon_on = 1'b0;
        $display("[TB] job K=%0d W=%0d mode=%0d abort_at=%0d beats=%0d", k, w, mode, abort_at, beat_idx);
    endtask

    task automatic cfg_err_case(input int k, input int w);
        @(posedge clk); #1;
        bus.start           = 1'b1;
        bus.cfg_kernel_size = 4'(k);
        bus.cfg_row_len     = AW'(w);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("cfg_err_pulse", bus.cfg_err, 1);
        check("cfg_err_busy", bus.busy, 0);
        @(posedge clk); #1;
        check("cfg_err_clear", bus.cfg_err, 0);
        check("cfg_err_busy2", bus.busy, 0);
        $display("[TB] cfg reject K=%0d W=%0d", k, w);
    endtask

    initial begin
        rstn                = 1'b0;
        bus.start           = 1'b0;
        bus.abort           = 1'b0;
        bus.cfg_kernel_size = 4'd0;
        bus.cfg_row_len     = '0;
        bus.out_ready       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rstn = 1'b1;

        run_job(3, 8, 0, 0);
        run_job(3, 8, 1, 0);
        cfg_err_case(0, 8);
        cfg_err_case(4, 8);
        cfg_err_case(3, 2);
        run_job(1, 4, 0, 0);
        run_job(3, 8, 0, 5);
        run_job(2, 5, 0, 0);

        // start together with abort is ignored
        @(posedge clk); #1;
        bus.start = 1'b1; bus.abort = 1'b1;
        bus.cfg_kernel_size = 4'd2; bus.cfg_row_len = AW'(6);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_abort_busy", bus.busy, 0);
        check("start_abort_err", bus.cfg_err, 0);
        $display("[TB] start+abort ignored");

        // reset in the middle of RUN
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cfg_kernel_size = 4'd3; bus.cfg_row_len = AW'(8);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrun_busy", bus.busy, 1);
        rstn = 1'b0;
        #1;
        check_reset_vals("arst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("arst_hold");
        @(posedge clk); #1;
        rstn = 1'b1;
        $display("[TB] reset mid-run");
        run_job(3, 8, 2, 0);

        for (int j = 0; j < 8; j++) begin
            int k;
            int w;
            k = $urandom_range(1, 3);
            w = $urandom_range(k, 16);
            run_job(k, w, $urandom_range(0, 2), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
